// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
// Holds the sequencer state encoding and the load-use detection rule.
package hazard_pkg;

    localparam int REG_W = 5;

    typedef enum logic {
        RUN   = 1'b0,
        MULTI = 1'b1
    } hctrl_state_t;

    function automatic logic load_use_hit(
        input logic             mem_read,
        input logic             reg_write,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2,
        input logic             use1,
        input logic             use2
    );
        logic src_match;
        src_match = (use1 && (rs1 == rd)) || (use2 && (rs2 == rd));
        return mem_read && reg_write && (rd != '0) && src_match;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter used for pipeline performance statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (rst) begin
            count_d = '0;
        end else if (inc && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, mul/div
// sequencing, branch redirect, memory-wait freeze and perf counters.
module pipeline_hazard_ctrl #(
    parameter int N       = 32,
    parameter int REG_W   = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic             ex_multicycle,
    input  logic             ex_branch_taken,
    input  logic [N*2-1:0]   ex_branch_target,
    input  logic             dmem_busy,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_write_en,
    output logic             idex_flush,
    output logic             exmem_write_en,
    output logic             exmem_bubble,
    output logic             pc_redirect,
    output logic [N*2-1:0]   pc_redirect_target,
    output logic             busy_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    import hazard_pkg::*;

    localparam int CW = $clog2(MUL_LAT);

    hctrl_state_t  state_q;
    hctrl_state_t  state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          lu_hit;

    assign lu_hit = load_use_hit(ex_mem_read, ex_reg_write, ex_rd,
                                 id_rs1, id_rs2,
                                 id_uses_rs1, id_uses_rs2);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_write_en    = 1'b1;
        ifid_write_en  = 1'b1;
        idex_write_en  = 1'b1;
        exmem_write_en = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        exmem_bubble   = 1'b0;
        pc_redirect    = 1'b0;

        if (rst) begin
            pc_write_en    = 1'b0;
            ifid_write_en  = 1'b0;
            idex_write_en  = 1'b0;
            exmem_write_en = 1'b0;
            state_d        = RUN;
            cnt_d          = '0;
        end else if (dmem_busy) begin
            pc_write_en    = 1'b0;
            ifid_write_en  = 1'b0;
            idex_write_en  = 1'b0;
            exmem_write_en = 1'b0;
        end else if (state_q == MULTI) begin
            // Release cycle keeps default enables so the result lands in EX/MEM
            if (cnt_q != '0) begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_write_en = 1'b0;
                exmem_bubble  = 1'b1;
                cnt_d         = cnt_q - CW'(1);
            end else begin
                state_d = RUN;
            end
        end else if (ex_branch_taken) begin
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (ex_multicycle) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_write_en = 1'b0;
            exmem_bubble  = 1'b1;
            state_d       = MULTI;
            cnt_d         = CW'(MUL_LAT - 2);
        end else if (lu_hit) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_flush    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    assign busy_state         = (state_q == MULTI);
    assign pc_redirect_target = ex_branch_target;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!rst && !pc_write_en),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_redirect),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus random bench for pipeline_hazard_ctrl against a
// cycle-count reference model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

    localparam int N       = 32;
    localparam int REG_W   = 5;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2;
    logic             ex_mem_read, ex_reg_write, ex_multicycle;
    logic             ex_branch_taken, dmem_busy;
    logic [N*2-1:0]   ex_branch_target;
    logic             pc_write_en, ifid_write_en, ifid_flush;
    logic             idex_write_en, idex_flush;
    logic             exmem_write_en, exmem_bubble;
    logic             pc_redirect, busy_state;
    logic [N*2-1:0]   pc_redirect_target;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int n_cmp = 0;
    int n_err = 0;

    // Model: cycles left in the current multi-cycle op (0 = not busy)
    int     m_left = 0;
    longint m_stall = 0;
    longint m_flush = 0;
    localparam longint SAT = (64'd1 << CNT_W) - 1;

    logic e_pc, e_ifid, e_ifid_fl, e_idex, e_idex_fl;
    logic e_exmem, e_bub, e_redir;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .N(N), .REG_W(REG_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .id_rs1             (id_rs1),
        .id_rs2             (id_rs2),
        .id_uses_rs1        (id_uses_rs1),
        .id_uses_rs2        (id_uses_rs2),
        .ex_rd              (ex_rd),
        .ex_mem_read        (ex_mem_read),
        .ex_reg_write       (ex_reg_write),
        .ex_multicycle      (ex_multicycle),
        .ex_branch_taken    (ex_branch_taken),
        .ex_branch_target   (ex_branch_target),
        .dmem_busy          (dmem_busy),
        .pc_write_en        (pc_write_en),
        .ifid_write_en      (ifid_write_en),
        .ifid_flush         (ifid_flush),
        .idex_write_en      (idex_write_en),
        .idex_flush         (idex_flush),
        .exmem_write_en     (exmem_write_en),
        .exmem_bubble       (exmem_bubble),
        .pc_redirect        (pc_redirect),
        .pc_redirect_target (pc_redirect_target),
        .busy_state         (busy_state),
        .stall_cycles       (stall_cycles),
        .flush_events       (flush_events)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic lu_rule();
        logic m1, m2;
        m1 = id_uses_rs1 && (id_rs1 == ex_rd);
        m2 = id_uses_rs2 && (id_rs2 == ex_rd);
        return ex_mem_read && ex_reg_write && (ex_rd != 0) && (m1 || m2);
    endfunction

    task automatic model_outputs();
        logic stall;
        {e_pc, e_ifid, e_idex, e_exmem} = 4'b1111;
        {e_ifid_fl, e_idex_fl, e_bub, e_redir} = 4'b0000;
        stall = 1'b0;
        if (rst || dmem_busy) begin
            {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
        end else if (m_left > 0) begin
            stall = (m_left > 1);
        end else if (ex_branch_taken) begin
            {e_redir, e_ifid_fl, e_idex_fl} = 3'b111;
        end else if (ex_multicycle) begin
            stall = 1'b1;
        end else if (lu_rule()) begin
            {e_pc, e_ifid, e_idex_fl} = 3'b001;
        end
        if (stall) begin
            {e_pc, e_ifid, e_idex, e_bub} = 4'b0001;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_left  = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!e_pc && m_stall < SAT) m_stall++;
            if (e_redir && m_flush < SAT) m_flush++;
            if (!dmem_busy) begin
                if (m_left > 0) m_left--;
                else if (!ex_branch_taken && ex_multicycle)
                    m_left = MUL_LAT - 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_outputs();
        chk("pc_write_en",    64'(pc_write_en),    64'(e_pc));
        chk("ifid_write_en",  64'(ifid_write_en),  64'(e_ifid));
        chk("ifid_flush",     64'(ifid_flush),     64'(e_ifid_fl));
        chk("idex_write_en",  64'(idex_write_en),  64'(e_idex));
        chk("idex_flush",     64'(idex_flush),     64'(e_idex_fl));
        chk("exmem_write_en", 64'(exmem_write_en), 64'(e_exmem));
        chk("exmem_bubble",   64'(exmem_bubble),   64'(e_bub));
        chk("pc_redirect",    64'(pc_redirect),    64'(e_redir));
        chk("redirect_tgt",   pc_redirect_target,  ex_branch_target);
        chk("busy_state",     64'(busy_state),     64'(m_left > 0));
        chk("stall_cycles",   64'(stall_cycles),   64'(m_stall));
        chk("flush_events",   64'(flush_events),   64'(m_flush));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 0; dmem_busy = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_mem_read = 0; ex_reg_write = 0;
        ex_multicycle = 0; ex_branch_taken = 0;
        ex_branch_target = 64'h0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;

        // Reset mid-MULTI
        rst = 0;
        tick();
        ex_multicycle = 1;
        tick();
        tick();
        ex_multicycle = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        @(negedge clk);
        chk("rst_busy", 64'(busy_state), 64'd0);
        chk("rst_stall0", stall_cycles, 64'd0);
        chk("rst_pc_we", 64'(pc_write_en), 64'd1);
        #1;
        @(posedge clk);
        #1;

        // Load-use on rs2
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5;
        id_rs2 = 5; id_uses_rs2 = 1;
        tick();
        idle();
        tick();
        chk("lu_stall1", stall_cycles, 64'd1);

        // x0 destination and unused rs1 never stall
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 0;
        id_rs1 = 0; id_uses_rs1 = 1;
        tick();
        ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 0;
        tick();
        idle();

        // Multi-cycle op: 3 stall cycles then release
        ex_multicycle = 1;
        repeat (MUL_LAT) tick();
        ex_multicycle = 0;
        tick();
        chk("mul_stall4", stall_cycles, 64'd4);

        // Taken branch beats a simultaneous load-use
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3;
        id_rs1 = 3; id_uses_rs1 = 1;
        ex_branch_taken = 1;
        ex_branch_target = 64'h0000_0000_0000_1040;
        tick();
        idle();
        tick();
        chk("br_flush1", flush_events, 64'd1);
        chk("br_stall4", stall_cycles, 64'd4);

        // Memory wait during MULTI with a pending branch
        ex_multicycle = 1;
        tick();
        tick();
        dmem_busy = 1;
        ex_branch_taken = 1;
        ex_branch_target = 64'h0000_0000_0000_2000;
        repeat (3) tick();
        dmem_busy = 0;
        tick();
        tick();
        ex_multicycle = 0;
        tick();
        idle();
        tick();
        chk("dm_stall10", stall_cycles, 64'd10);
        chk("dm_flush2", flush_events, 64'd2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 3);
            dmem_busy = ($urandom_range(0, 99) < 15);
            ex_branch_taken = ($urandom_range(0, 99) < 12);
            ex_multicycle = ($urandom_range(0, 99) < 15);
            ex_mem_read = $urandom_range(0, 1);
            ex_reg_write = ($urandom_range(0, 3) != 0);
            ex_rd = REG_W'($urandom_range(0, 3));
            id_rs1 = REG_W'($urandom_range(0, 3));
            id_rs2 = REG_W'($urandom_range(0, 3));
            id_uses_rs1 = $urandom_range(0, 1);
            id_uses_rs2 = $urandom_range(0, 1);
            ex_branch_target = {$urandom, $urandom};
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
